// File: rtl/apple_1_pia.sv
// Apple-1 keyboard/display PIA at BASE_ADDR..BASE_ADDR+3: CPU bus responder with
// a keyboard FIFO stream in and a single-character display stream out.
module apple_1_pia #(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int unsigned KBD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic        RDY,
    output logic [7:0]  DI,
    output logic        sel,
    input  logic        kbd_valid,
    input  logic [6:0]  kbd_data,
    output logic        kbd_ready,
    output logic        dsp_valid,
    output logic [6:0]  dsp_data,
    input  logic        dsp_ready
);

    localparam int unsigned PTR_W = $clog2(KBD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [6:0]       fifo_q [KBD_DEPTH];
    logic [6:0]       fifo_d [KBD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic [6:0]       last_dsp_q, last_dsp_d;
    logic [7:0]       di_q, di_d;
    logic             sel_q, sel_d;

    logic       hit, rd, wr, empty, full, push, pop, dsp_done;
    logic [1:0] off;
    logic [7:0] rdata;
    logic       unused_do7;

    assign unused_do7 = DO[7];

    assign hit   = (AB[15:2] == BASE_ADDR[15:2]) && RDY;
    assign rd    = hit && !WE;
    assign wr    = hit && WE;
    assign off   = AB[1:0];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(KBD_DEPTH));

    assign kbd_ready = !full && !reset;
    assign push      = kbd_valid && kbd_ready;
    // A KBD read only pops what was already queued before this edge.
    assign pop       = rd && (off == 2'd0) && !empty;
    assign dsp_done  = busy_q && dsp_ready;

    // Register read mux
    always_comb begin
        rdata = 8'h00;
        case (off)
            2'd0:    rdata = empty ? 8'h80 : {1'b1, fifo_q[rd_ptr_q]};
            2'd1:    rdata = {!empty, ovf_q, 6'b0};
            2'd2:    rdata = {busy_q, last_dsp_q};
            default: rdata = 8'h00;
        endcase
    end

    // Next-state for FIFO, flags, display and read path
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        last_dsp_d = last_dsp_q;
        di_d       = rd ? rdata : 8'h00;
        sel_d      = rd;

        if (push) begin
            fifo_d[wr_ptr_q] = kbd_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Overflow set wins over a same-cycle clear so no drop goes unreported.
        if (wr && (off == 2'd1) && DO[6]) begin
            ovf_d = 1'b0;
        end
        if (kbd_valid && full) begin
            ovf_d = 1'b1;
        end

        // busy is sampled before the handshake clears it, so a racing write drops.
        if (wr && (off == 2'd2) && !busy_q) begin
            busy_d     = 1'b1;
            last_dsp_d = DO[6:0];
        end else if (dsp_done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            last_dsp_q <= 7'h00;
            di_q       <= 8'h00;
            sel_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            last_dsp_q <= last_dsp_d;
            di_q       <= di_d;
            sel_q      <= sel_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign DI        = di_q;
    assign sel       = sel_q;
    assign dsp_valid = busy_q;
    assign dsp_data  = last_dsp_q;

endmodule

// File: doc/apple_1_pia.md
Name: apple_1_pia

Overview:
- Bus-responder side of the Apple-1 6502 CPU bus: the keyboard/display PIA at $D010-$D013.
- Decodes the CPU address/write-data/write-enable, returns registered read data on the CPU data-in path, and performs the Woz-Mon-compatible register side effects.
- Terminal side is two valid/ready streams: keyboard characters in, display characters out.
- Sits beside the CPU core inside the apple_1 top and is driven by the SystemC co-simulation terminal model.

Parameters:
- BASE_ADDR, 16'hD010, register block base address; must be 4-byte aligned.
- KBD_DEPTH, 4, keyboard FIFO depth; power of 2, minimum 2.

Ports:
- clk  input  1  CPU clock.
- reset  input  1  synchronous, active-high reset.
- AB  input  16  CPU address bus.
- DO  input  8  CPU write data.
- WE  input  1  CPU write enable; 1 = write cycle.
- RDY  input  1  CPU ready; all register accesses are ignored when 0.
- DI  output  8  read data to CPU; registered.
- sel  output  1  registered; 1 when DI carries a read from this block (used by the top-level DI mux).
- kbd_valid  input  1  keyboard character offered.
- kbd_data  input  7  ASCII keyboard character.
- kbd_ready  output  1  keyboard FIFO can accept a character.
- dsp_valid  output  1  display character pending.
- dsp_data  output  7  ASCII display character.
- dsp_ready  input  1  terminal accepts the display character.

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous and active-high. All state updates on the rising edge of clk.
- Hit: AB[15:2]==BASE_ADDR[15:2] && RDY. The offset is AB[1:0].
  - Read = hit && !WE.
  - Write = hit && WE; uses DO in the same cycle.
- Read latency is 1 cycle: the value for AB at cycle n appears on DI at n+1, with sel=1.
  - On a non-hit cycle: DI=8'h00 and sel=0 on the next cycle.
- Register map:
  - Offset 0, KBD (read): {1, FIFO head[6:0]}. Returns 8'h80 when empty. A read pops the head if the FIFO is non-empty. Writes are ignored.
  - Offset 1, KBDCR (read): {!empty, ovf, 6'b0}. A write with DO[6]=1 clears ovf. Other bits are ignored.
  - Offset 2, DSP (read): {busy, last_dsp[6:0]}.
    - Write when busy=0: last_dsp<=DO[6:0], busy<=1.
    - Write when busy=1: dropped, no state change.
  - Offset 3, DSPCR: reads 8'h00. Writes are ignored.
- Keyboard FIFO:
  - kbd_ready = !full && !reset.
  - Push on kbd_valid && kbd_ready.
  - kbd_valid && full sets sticky ovf; the character is dropped.
  - Push and pop in the same cycle (non-empty, non-full): both occur and the count is unchanged.
  - Push into an empty FIFO in the same cycle as a KBD read: the read returns 8'h80, no pop occurs, and the count becomes 1.
  - Pointers wrap modulo KBD_DEPTH. Count width is clog2(KBD_DEPTH)+1.
- Display:
  - dsp_valid = busy; dsp_data = last_dsp.
  - On dsp_valid && dsp_ready, busy<=0 at that edge.
  - A DSP write in the same cycle as handshake completion is dropped, because busy is sampled as 1.
  - dsp_data is held stable while dsp_valid=1.
- Reset (synchronous, takes priority over everything):
  - DI=0, sel=0, busy=0 (dsp_valid=0), dsp_data=0, ovf=0, FIFO empty.
  - kbd_ready=0 during reset.
  - Reset asserted mid-handshake discards the pending character. It does not re-present after reset.
- RDY=0: no pops, no writes. DI/sel are updated as for a non-hit cycle. FIFO push and display handshake continue independently of RDY.

Test Plan:
1. Reset, then push 'A' (7'h41) via kbd_valid → KBDCR read returns 8'h80. KBD read returns 8'hC1 and pops. Next KBDCR read returns 8'h00 and next KBD read returns 8'h80.
2. Push 5 chars 41..45 with KBD_DEPTH=4 → kbd_ready falls after the 4th. KBDCR read returns 8'hC0 (ovf). Write 8'h40 to $D011 → KBDCR read returns 8'h80. KBD reads return C1,C2,C3,C4.
3. Write 8'h8D to $D012 with dsp_ready=0 → dsp_valid=1, dsp_data=7'h0D, DSP read returns 8'h8D. A second write of 8'h41 is dropped. Raise dsp_ready for 1 cycle → dsp_valid=0 and DSP read returns 8'h0D.
4. DSP write at the exact cycle dsp_valid && dsp_ready completes → the new char is dropped and dsp_valid=0 next cycle. Read-latency check: AB=$D011 at cycle n gives DI/sel at n+1. AB=$C000 gives DI=00, sel=0.
5. KBD read with RDY=0 on a FIFO holding 'B' → no pop. The same read with RDY=1 returns 8'hC2 and empties the FIFO. Simultaneous push 'C' and KBD pop of 'B' → count stays 1 and the next read returns 8'hC3.
6. Assert reset with busy=1 and 3 keys queued → after reset dsp_valid=0, KBDCR read returns 8'h00, kbd_ready=1, DI=0, sel=0.
